// File: rtl/mon_mem_access.sv
// UART-monitor memory engine: word writes, ranged line dumps, memory fill.
// Optional MON_FILL_PAT_EN: fill with a cmd_data pattern instead of zeros.
module mon_mem_access #(
  parameter int DBUS_W    = 128,
  parameter int SND_WORDS = 2,
  parameter int FILL_AW   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             cmd_data,
  input  logic                    wadr_set,
  input  logic                    wdata_en,
  input  logic                    rd_start_set,
  input  logic                    rd_end_set,
  input  logic                    rd_stop,
  input  logic                    fill_start,
  output logic                    mem_rreq,
  output logic [31:0]             mem_radr,
  input  logic                    mem_rvalid,
  input  logic [DBUS_W-1:0]       mem_rdata,
  output logic                    mem_wen,
  output logic [31:0]             mem_wadr,
  output logic [DBUS_W-1:0]       mem_wdata,
  output logic [DBUS_W/8-1:0]     mem_wmask,
  output logic                    snd_start,
  output logic [32*SND_WORDS-1:0] snd_data,
  input  logic                    snd_done,
  output logic                    busy,
  output logic                    fill_running
);

  localparam int LANES = DBUS_W / 32;
  localparam int LB    = $clog2(LANES);
  localparam int LBW   = (LB > 0) ? LB : 1;
  localparam int OB    = LB + 2;
  localparam int MW    = DBUS_W / 8;
  localparam int SW    = 32 * SND_WORDS;
  localparam logic [31:0] NLINE = 32'((2 ** FILL_AW) / LANES);
  localparam logic [31:0] AMASK = ~((32'd1 << OB) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, GATH, SEND
  } st_t;

  st_t               state_q, state_d;
  logic [29:0]       wptr_q;
  logic [29:0]       end_q;
  logic [30:0]       rptr_q;
  logic [30:0]       tag_q;
  logic [2:0]        k_q;
  logic [DBUS_W-1:0] line_q;
  logic [SW-1:0]     slot_q;
  logic              snd_q;
  logic              fill_q;
  logic [31:0]       fcnt_q;
  logic [31:0]       pat;
  logic              take, hit;
  logic              wr_fire, fill_go, dump_go;
  logic [LBW-1:0]    rlane, wlane;

  assign busy         = (state_q != IDLE);
  assign fill_running = fill_q;
  assign snd_start    = snd_q;
  assign snd_data     = slot_q;

  assign dump_go = (state_q == IDLE) && rd_end_set && !fill_q;
  assign fill_go = fill_start && !busy && !fill_q;
  assign wr_fire = wdata_en && !wadr_set && !fill_q;

  assign rlane = rptr_q[LBW-1:0] & LBW'(LANES - 1);
  assign wlane = wptr_q[LBW-1:0] & LBW'(LANES - 1);
  assign hit   = ((rptr_q >> LB) == tag_q);

  assign mem_rreq = (state_q == REQ);
  assign mem_radr = mem_rreq ? ({rptr_q[29:0], 2'b00} & AMASK) : '0;
  assign mem_wen  = wr_fire | fill_q;

`ifdef MON_FILL_PAT_EN
  logic [31:0] pat_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pat_q <= '0;
    else if (fill_go) pat_q <= cmd_data;
  end
  assign pat = pat_q;
`else
  assign pat = '0;
`endif

  always_comb begin
    mem_wadr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (fill_q) begin
      mem_wadr  = fcnt_q << OB;
      mem_wmask = '1;
      mem_wdata = {LANES{pat}};
    end else if (wr_fire) begin
      mem_wadr  = {wptr_q, 2'b00} & AMASK;
      mem_wmask = MW'(4'hF) << {wlane, 2'b00};
      mem_wdata = {LANES{cmd_data}};
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: if (dump_go) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: if (mem_rvalid) state_d = GATH;
      GATH: begin
        if (hit) begin
          take = 1'b1;
          if (k_q == 3'(SND_WORDS - 1)) state_d = SEND;
        end else begin
          state_d = REQ;
        end
      end
      SEND: begin
        // end check only at send boundaries, so the last send is full
        if (snd_done) begin
          if (rptr_q > {1'b0, end_q}) state_d = IDLE;
          else                        state_d = GATH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_stop && state_q != IDLE) begin
      state_d = IDLE;
      take    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snd_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      end_q   <= '0;
      tag_q   <= '0;
      k_q     <= '0;
      line_q  <= '0;
      slot_q  <= '0;
      fill_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      snd_q   <= (state_d == SEND) && (state_q != SEND);
      if (wadr_set && !fill_q) wptr_q <= cmd_data[31:2];
      else if (wr_fire)        wptr_q <= wptr_q + 30'd1;
      if (!busy && rd_start_set) rptr_q <= {1'b0, cmd_data[31:2]};
      else if (take)             rptr_q <= rptr_q + 31'd1;
      if (dump_go) end_q <= cmd_data[31:2];
      if (state_q == IDLE || (state_q == SEND && snd_done))
        k_q <= '0;
      else if (take)
        k_q <= k_q + 3'd1;
      if (state_q == WAIT && mem_rvalid) begin
        line_q <= mem_rdata;
        tag_q  <= rptr_q >> LB;
      end
      if (take) slot_q[32*k_q +: 32] <= line_q[32*rlane +: 32];
      if (fill_go) begin
        fill_q <= 1'b1;
        fcnt_q <= '0;
      end else if (fill_q) begin
        fcnt_q <= fcnt_q + 32'd1;
        if (fcnt_q == NLINE - 32'd1) fill_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mon_mem_access.sv
// Bench for mon_mem_access: scoreboarded writes, line reads and sends.
// Memory model answers reads; UART model answers sends with snd_done.
module tb_mon_mem_access;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cmd_data;
  logic         wadr_set, wdata_en, rd_start_set, rd_end_set;
  logic         rd_stop, fill_start;
  logic         mem_rreq;
  logic [31:0]  mem_radr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         mem_wen;
  logic [31:0]  mem_wadr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wmask;
  logic         snd_start;
  logic [63:0]  snd_data;
  logic         snd_done;
  logic         busy, fill_running;

  mon_mem_access #(
    .DBUS_W(128), .SND_WORDS(2), .FILL_AW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data),
    .wadr_set(wadr_set), .wdata_en(wdata_en),
    .rd_start_set(rd_start_set), .rd_end_set(rd_end_set),
    .rd_stop(rd_stop), .fill_start(fill_start),
    .mem_rreq(mem_rreq), .mem_radr(mem_radr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wadr(mem_wadr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .snd_start(snd_start), .snd_data(snd_data),
    .snd_done(snd_done), .busy(busy),
    .fill_running(fill_running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  adr;
    logic [15:0]  m;
    logic [127:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [63:0] sq[$];

  int total = 0;
  int bad   = 0;
  int nsend = 0;
  int lat   = 2;
  int rcnt  = 0;
  int dcnt  = 0;
  bit auto_done = 1'b1;
  logic [31:0] radr_p;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wv(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = wv(a + 32'(4 * i));
    return l;
  endfunction

  function automatic wr_t mkw(input logic [31:0] a, input logic [15:0] m,
                              input logic [127:0] d);
    wr_t w;
    w.adr = a; w.m = m; w.d = d;
    return w;
  endfunction

  // memory/UART models and output monitor, away from the active edge
  always @(negedge clk) begin
    wr_t w;
    mem_rvalid = 1'b0;
    snd_done   = 1'b0;
    if (rcnt != 0) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = line(radr_p);
      end
    end
    if (dcnt != 0) begin
      dcnt--;
      if (dcnt == 0) snd_done = 1'b1;
    end
    if (rst_n && mem_rreq) begin
      if (rq.size() == 0) chk("rd_unexp", 1, 0);
      else chk("rd_adr", mem_radr, rq.pop_front());
      radr_p = mem_radr;
      rcnt   = lat;
    end
    if (rst_n && mem_wen) begin
      if (wq.size() == 0) chk("wr_unexp", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_adr", mem_wadr, w.adr);
        chk("wr_mask", mem_wmask, w.m);
        chk("wr_data", mem_wdata, w.d);
      end
    end
    if (rst_n && snd_start) begin
      nsend++;
      if (sq.size() == 0) chk("snd_unexp", 1, 0);
      else chk("snd_data", snd_data, sq.pop_front());
      if (auto_done) dcnt = 3;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) cyc(1);
    chk("idle_to", busy, 0);
  endtask

  task automatic dump(input logic [31:0] s, input logic [31:0] e);
    cmd_data = s; rd_start_set = 1'b1; cyc(1); rd_start_set = 1'b0;
    cmd_data = e; rd_end_set = 1'b1; cyc(1); rd_end_set = 1'b0;
    chk("busy_hi", busy, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fill"}, fill_running, 0);
    chk({tag, "_rreq"}, mem_rreq, 0);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_snd"}, snd_start, 0);
    chk({tag, "_sdat"}, snd_data, 0);
    chk({tag, "_wadr"}, mem_wadr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [127:0] fpat;
    rst_n = 1'b0; cmd_data = '0;
    wadr_set = 0; wdata_en = 0; rd_start_set = 0; rd_end_set = 0;
    rd_stop = 0; fill_start = 0; mem_rvalid = 0; mem_rdata = '0;
    snd_done = 0;
    cyc(2);
    chk_zero("rst");
    rst_n = 1'b1;
    cyc(1);

    // word writes, lane masks, line crossing, load-wins
    cmd_data = 32'h1008; wadr_set = 1'b1; cyc(1); wadr_set = 1'b0;
    wq.push_back(mkw(32'h1000, 16'h0F00, {4{32'hA}}));
    wq.push_back(mkw(32'h1000, 16'hF000, {4{32'hB}}));
    wq.push_back(mkw(32'h1010, 16'h000F, {4{32'hC}}));
    wdata_en = 1'b1;
    cmd_data = 32'hA; cyc(1);
    cmd_data = 32'hB; cyc(1);
    cmd_data = 32'hC; cyc(1);
    cmd_data = 32'h2000; wadr_set = 1'b1; cyc(1); wadr_set = 1'b0;
    wq.push_back(mkw(32'h2000, 16'h000F, {4{32'hD}}));
    cmd_data = 32'hD; cyc(1); wdata_en = 1'b0;
    cyc(1);
    chk("wq_t1", wq.size(), 0);

    // dump across two lines; busy-time reloads ignored
    n0 = nsend;
    rq.push_back(32'h1000);
    rq.push_back(32'h1010);
    sq.push_back({wv(32'h1008), wv(32'h1004)});
    sq.push_back({wv(32'h1010), wv(32'h100C)});
    dump(32'h1004, 32'h1010);
    cmd_data = 32'h3000; rd_start_set = 1'b1; cyc(1); rd_start_set = 1'b0;
    cmd_data = 32'h2000; rd_end_set = 1'b1; cyc(1); rd_end_set = 1'b0;
    wait_idle();
    chk("t2_sends", nsend - n0, 2);
    chk("t2_rq", rq.size(), 0);

    // stop while waiting for the line; late rvalid ignored
    lat = 3;
    n0 = nsend;
    rq.push_back(32'h2000);
    dump(32'h2000, 32'h2010);
    cyc(1);
    rd_stop = 1'b1; cyc(1); rd_stop = 1'b0;
    chk("t3_busy", busy, 0);
    cyc(6);
    chk("t3_busy2", busy, 0);
    chk("t3_sends", nsend - n0, 0);
    lat = 2;

    // fill, with writes/dump requests dropped meanwhile
`ifdef MON_FILL_PAT_EN
    fpat = {4{32'h5A5A5A5A}};
`else
    fpat = '0;
`endif
    for (int i = 0; i < 4; i++)
      wq.push_back(mkw(32'(16 * i), 16'hFFFF, fpat));
    cmd_data = 32'h5A5A5A5A; fill_start = 1'b1; cyc(1); fill_start = 1'b0;
    chk("t4_run", fill_running, 1);
    cmd_data = 32'h9000; wdata_en = 1'b1; wadr_set = 1'b1; cyc(1);
    wadr_set = 1'b0; cmd_data = 32'h77; rd_end_set = 1'b1; cyc(1);
    wdata_en = 1'b0; rd_end_set = 1'b0;
    chk("t4_nodump", busy, 0);
    cyc(2);
    chk("t4_done", fill_running, 0);
    chk("t4_wq", wq.size(), 0);
    wq.push_back(mkw(32'h2000, 16'h00F0, {4{32'hE}}));
    cmd_data = 32'hE; wdata_en = 1'b1; cyc(1); wdata_en = 1'b0;
    cyc(1);
    chk("t4_wptr", wq.size(), 0);

    // top-of-space range: one send, no wrap loop
    n0 = nsend;
    rq.push_back(32'hFFFF_FFF0);
    sq.push_back({wv(32'hFFFF_FFFC), wv(32'hFFFF_FFF8)});
    dump(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    wait_idle();
    cyc(4);
    chk("t5_sends", nsend - n0, 1);

    // reset while holding in SEND, then a fresh dump
    auto_done = 1'b0;
    n0 = nsend;
    rq.push_back(32'h4000);
    sq.push_back({wv(32'h4004), wv(32'h4000)});
    dump(32'h4000, 32'h4004);
    for (int i = 0; i < 50 && nsend == n0; i++) cyc(1);
    chk("t6_snd", nsend - n0, 1);
    cyc(2);
    chk("t6_hold", busy, 1);
    rst_n = 1'b0; #1;
    chk_zero("t6");
    cyc(1);
    rst_n = 1'b1; auto_done = 1'b1;
    cyc(1);
    n0 = nsend;
    rq.push_back(32'h5000);
    sq.push_back({wv(32'h500C), wv(32'h5008)});
    dump(32'h5008, 32'h500C);
    wait_idle();
    chk("t6_sends", nsend - n0, 1);

    cyc(5);
    chk("end_wq", wq.size(), 0);
    chk("end_rq", rq.size(), 0);
    chk("end_sq", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
